// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: STAGES slices of WIDTH/STAGES bits with a
// registered carry between slices. Define SATURATE_EN to clamp signed overflow in the last stage.
module pipelined_cla_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int GROUP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_A,
  input  logic [WIDTH-1:0] data_B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             saturated
);

  localparam int SW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;

  // Group-lookahead carries inside each GROUP, rippling group to group.
  function automatic logic [SW:0] cla_slice(input logic [SW-1:0] a,
                                            input logic [SW-1:0] b,
                                            input logic          cin);
    logic [SW-1:0] p, g;
    logic [SW:0]   c;
    logic          gg, pp;
    int            base;
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    c[0] = cin;
    for (int grp = 0; grp < SW / GROUP; grp++) begin
      base = grp * GROUP;
      for (int i = 0; i < GROUP; i++) begin
        gg = 1'b0;
        pp = 1'b1;
        for (int j = 0; j <= i; j++) begin
          gg = g[base+j] | (p[base+j] & gg);
          pp = pp & p[base+j];
        end
        c[base+i+1] = gg | (pp & c[base]);
      end
    end
    return {c[SW], p ^ c[SW-1:0]};
  endfunction

  logic [STAGES-1:0] r_v;
  logic [STAGES-1:0] w_adv;
  logic [STAGES-1:0] w_vin;
  logic [WIDTH-1:0]  w_b_eff;
  logic              w_cin_eff;

  assign w_b_eff   = sub ? ~data_B : data_B;
  assign w_cin_eff = sub | Cin;

  always_comb begin
    w_adv    = '0;
    w_vin    = '0;
    w_adv[L] = !r_v[L] || out_ready;
    for (int k = L - 1; k >= 0; k--) w_adv[k] = !r_v[k] || w_adv[k+1];
    w_vin[0] = in_valid;
    for (int k = 1; k < STAGES; k++) w_vin[k] = r_v[k-1];
  end

  assign in_ready  = w_adv[0];
  assign out_valid = r_v[L];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_adv[k]) r_v[k] <= w_vin[k];
      end
    end
  end

  // Stage k keeps the resolved low sum bits and only the operand bits not yet consumed.
  for (genvar k = 0; k < L; k++) begin : g_pipe
    localparam int LO = (k + 1) * SW;
    localparam int HI = WIDTH - LO;
    logic [SW-1:0] w_sa, w_sb;
    logic          w_sc;
    logic [SW:0]   w_slice;
    logic [HI-1:0] w_a_rest, w_b_rest;
    logic [LO-1:0] w_s_nxt;
    logic [HI-1:0] r_a, r_b;
    logic [LO-1:0] r_s;
    logic          r_c;

    if (k == 0) begin : g_src
      assign w_sa     = data_A[SW-1:0];
      assign w_sb     = w_b_eff[SW-1:0];
      assign w_sc     = w_cin_eff;
      assign w_a_rest = data_A[WIDTH-1:SW];
      assign w_b_rest = w_b_eff[WIDTH-1:SW];
      assign w_s_nxt  = w_slice[SW-1:0];
    end else begin : g_src
      assign w_sa     = g_pipe[k-1].r_a[SW-1:0];
      assign w_sb     = g_pipe[k-1].r_b[SW-1:0];
      assign w_sc     = g_pipe[k-1].r_c;
      assign w_a_rest = g_pipe[k-1].r_a[HI+SW-1:SW];
      assign w_b_rest = g_pipe[k-1].r_b[HI+SW-1:SW];
      assign w_s_nxt  = {w_slice[SW-1:0], g_pipe[k-1].r_s};
    end

    assign w_slice = cla_slice(w_sa, w_sb, w_sc);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_a <= '0;
        r_b <= '0;
        r_s <= '0;
        r_c <= 1'b0;
      end else if (w_adv[k] && w_vin[k]) begin
        r_a <= w_a_rest;
        r_b <= w_b_rest;
        r_s <= w_s_nxt;
        r_c <= w_slice[SW];
      end
    end
  end

  logic [SW-1:0]    w_la, w_lb;
  logic             w_lc;
  logic [SW:0]      w_lslice;
  logic [WIDTH-1:0] w_sum, w_final;
  logic             w_cmsb, w_ovf;

  if (STAGES == 1) begin : g_last_src
    assign w_la  = data_A;
    assign w_lb  = w_b_eff;
    assign w_lc  = w_cin_eff;
    assign w_sum = w_lslice[SW-1:0];
  end else begin : g_last_src
    assign w_la  = g_pipe[L-1].r_a;
    assign w_lb  = g_pipe[L-1].r_b;
    assign w_lc  = g_pipe[L-1].r_c;
    assign w_sum = {w_lslice[SW-1:0], g_pipe[L-1].r_s};
  end

  assign w_lslice = cla_slice(w_la, w_lb, w_lc);
  assign w_cmsb   = w_sum[WIDTH-1] ^ w_la[SW-1] ^ w_lb[SW-1];
  assign w_ovf    = w_cmsb ^ w_lslice[SW];

`ifdef SATURATE_EN
  logic r_sat;
  // On overflow both operands share a sign; A's sign picks the clamp direction.
  assign w_final   = !w_ovf      ? w_sum :
                     w_la[SW-1]  ? {1'b1, {(WIDTH-1){1'b0}}} :
                                   {1'b0, {(WIDTH-1){1'b1}}};
  assign saturated = r_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_sat <= 1'b0;
    else if (w_adv[L] && w_vin[L]) r_sat <= w_ovf;
  end
`else
  assign w_final   = w_sum;
  assign saturated = 1'b0;
`endif

  logic [WIDTH-1:0] r_out;
  logic             r_cout, r_ovf, r_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_adv[L] && w_vin[L]) begin
      r_out  <= w_final;
      r_cout <= w_lslice[SW];
      r_ovf  <= w_ovf;
      r_zero <= (w_final == '0);
    end
  end

  assign out       = r_out;
  assign carry_out = r_cout;
  assign overflow  = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub: directed vectors, randomized traffic against an arithmetic
// reference model, a stall/back-to-back stream and reset while operations are in flight.
module tb_pipelined_cla_addsub;
  localparam int W  = 32;
  localparam int ST = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] data_A;
  logic [W-1:0] data_B;
  logic         Cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         carry_out;
  logic         overflow;
  logic         zero;
  logic         saturated;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] res;
    logic         co;
    logic         ovf;
    logic         z;
    logic         sat;
  } exp_t;

  pipelined_cla_addsub #(.WIDTH(W), .STAGES(ST), .GROUP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_A    (data_A),
    .data_B    (data_B),
    .Cin       (Cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero),
    .saturated (saturated)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "simulation timeout");
  end

  // Reference: plain 33-bit arithmetic, signed overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic s);
    logic [W-1:0] be;
    logic [W:0]   full;
    exp_t         e;
    be    = s ? ~b : b;
    full  = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (s ? 1'b1 : cin)};
    e.res = full[W-1:0];
    e.co  = full[W];
    e.ovf = (a[W-1] == be[W-1]) && (full[W-1] != a[W-1]);
    e.sat = 1'b0;
`ifdef SATURATE_EN
    if (e.ovf) begin
      e.res = a[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      e.sat = 1'b1;
    end
`endif
    e.z = (e.res == '0);
    return e;
  endfunction

  function automatic exp_t dut_obs();
    return {out, carry_out, overflow, zero, saturated};
  endfunction

  function automatic logic [W-1:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic run_single(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                            input logic s, output exp_t act, output int lat);
    lat       = -1;
    data_A    = a;
    data_B    = b;
    Cin       = cin;
    sub       = s;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (out_valid) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
    end
    act = dut_obs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; data_A = '0; data_B = '0;
    Cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid);
    end
    checks++;
    if (dut_obs() !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h exp 0", dut_obs());
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] va[4], vb[4], vres[4];
    logic         vcin[4], vsub[4], vco[4], vovf[4], vz[4], vsat[4];
    exp_t         act, e;
    int           lat;
    va[0] = 32'h0000_0000; vb[0] = 32'hFFFF_FFFF; vcin[0] = 0; vsub[0] = 0;
    vres[0] = 32'hFFFF_FFFF; vco[0] = 0; vovf[0] = 0; vz[0] = 0; vsat[0] = 0;
    va[1] = 32'h7FFF_FFFF; vb[1] = 32'h0000_0001; vcin[1] = 0; vsub[1] = 0;
    vco[1] = 0; vovf[1] = 1; vz[1] = 0;
`ifdef SATURATE_EN
    vres[1] = 32'h7FFF_FFFF; vsat[1] = 1;
`else
    vres[1] = 32'h8000_0000; vsat[1] = 0;
`endif
    va[2] = 32'hFFFF_FFFF; vb[2] = 32'h0000_0001; vcin[2] = 0; vsub[2] = 0;
    vres[2] = 32'h0000_0000; vco[2] = 1; vovf[2] = 0; vz[2] = 1; vsat[2] = 0;
    va[3] = 32'h0000_0005; vb[3] = 32'h0000_0007; vcin[3] = 1; vsub[3] = 1;
    vres[3] = 32'hFFFF_FFFE; vco[3] = 0; vovf[3] = 0; vz[3] = 0; vsat[3] = 0;
    for (int i = 0; i < 4; i++) begin
      run_single(va[i], vb[i], vcin[i], vsub[i], act, lat);
      e = {vres[i], vco[i], vovf[i], vz[i], vsat[i]};
      checks++;
      if (lat != ST) begin
        errors++; $display("FAIL directed_latency[%0d]: got %0d exp %0d", i, lat, ST);
      end
      checks++;
      if (act !== e) begin
        errors++; $display("FAIL directed_result[%0d]: got %h exp %h", i, act, e);
      end
      if (lat > 0) begin
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
          errors++; $display("FAIL directed_single_delivery[%0d]: got out_valid %b exp 0", i, out_valid);
        end
      end
    end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e, act, held;
    logic hold;
    hold = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      data_A    = rnd_operand();
      data_B    = rnd_operand();
      Cin       = 1'($urandom_range(0, 1));
      sub       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (hold) begin
        checks++;
        if (!out_valid || dut_obs() !== held) begin
          errors++; $display("FAIL random_hold: got %b/%h exp 1/%h", out_valid, dut_obs(), held);
        end
      end
      if (in_valid && in_ready) q.push_back(model(data_A, data_B, Cin, sub));
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL random_extra_result: got %h exp none", dut_obs());
        end else begin
          e   = q.pop_front();
          act = dut_obs();
          if (act !== e) begin
            errors++; $display("FAIL random_result: got %h exp %h", act, e);
          end
        end
      end
      hold = out_valid && !out_ready;
      held = dut_obs();
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 50 && q.size() > 0; n++) begin
      #1;
      if (out_valid) begin
        checks++;
        e   = q.pop_front();
        act = dut_obs();
        if (act !== e) begin
          errors++; $display("FAIL random_drain: got %h exp %h", act, e);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL random_lost: got %0d undelivered exp 0", q.size());
    end
  endtask

  task automatic test_back_to_back();
    exp_t q[$];
    exp_t e, act, held;
    logic hold, exp_rdy;
    int   idx, occ, delivered;
    idx = 0; occ = 0; delivered = 0; hold = 1'b0; held = '0;
    for (int n = 0; n < 40 && delivered < 8; n++) begin
      in_valid  = (idx < 8);
      data_A    = 32'(idx + 1);
      data_B    = 32'(idx + 1);
      Cin       = 1'b0;
      sub       = 1'b0;
      out_ready = (n >= 6);
      #1;
      exp_rdy = (occ < ST) || out_ready;
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++; $display("FAIL b2b_in_ready cyc %0d: got %b exp %b", n, in_ready, exp_rdy);
      end
      if (hold) begin
        checks++;
        if (!out_valid || dut_obs() !== held) begin
          errors++; $display("FAIL b2b_hold cyc %0d: got %h exp %h", n, dut_obs(), held);
        end
      end
      if (n >= 6 && n < 14) begin
        checks++;
        if (out_valid !== 1'b1) begin
          errors++; $display("FAIL b2b_stream cyc %0d: got out_valid %b exp 1", n, out_valid);
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(data_A, data_B, 1'b0, 1'b0));
        idx++;
        occ++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_extra_result: got %h exp none", dut_obs());
        end else begin
          e   = q.pop_front();
          act = dut_obs();
          if (act !== e) begin
            errors++; $display("FAIL b2b_result[%0d]: got %h exp %h", delivered, act, e);
          end
        end
        delivered++;
        occ--;
      end
      hold = out_valid && !out_ready;
      held = dut_obs();
      @(posedge clk); #1;
    end
    checks++;
    if (delivered != 8) begin
      errors++; $display("FAIL b2b_count: got %0d exp 8", delivered);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      data_A   = $urandom;
      data_B   = $urandom;
      Cin      = 1'($urandom_range(0, 1));
      sub      = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL midflight_precond: got out_valid %b exp 1", out_valid);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || dut_obs() !== '0) begin
      errors++; $display("FAIL midflight_async_clear: got %b/%h exp 0/0", out_valid, dut_obs());
    end
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL midflight_in_ready: got %b exp 1", in_ready);
    end
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL midflight_stale cyc %0d: got out_valid %b exp 0", n, out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
